// File: rtl/shift_reg_univ.sv
// ---------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal register: a WIDTH-bit bank of async-reset flops with
//   clock enable and eight operating modes (hold, load, logical/arithmetic
//   shift, rotate, clear). It also keeps a saturating count of shifts/rotates
//   since the last load, clear or reset.
//
// Ports
//   clk2      in   1      clock, rising-edge active
//   a_reset   in   1      asynchronous reset, active-high
//   en        in   1      clock enable; 0 = every register holds
//   mode      in   3      operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/ASR/CLR)
//   d         in   WIDTH  parallel load data
//   sin_l     in   1      serial in at MSB end (SHR)
//   sin_r     in   1      serial in at LSB end (SHL)
//   q         out  WIDTH  register contents
//   sout_l    out  1      q[WIDTH-1]
//   sout_r    out  1      q[0]
//   zero      out  1      registered flag, 1 when q is all zeros
//   shift_cnt out  CNT_W  saturating shift/rotate count since LOAD/CLR/reset
// ---------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int unsigned            WIDTH   = 8,
    parameter logic [WIDTH-1:0]       RST_VAL = '0,
    parameter int unsigned            CNT_W   = 4
) (
    input  logic             clk2,
    input  logic             a_reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero,
    output logic [CNT_W-1:0] shift_cnt
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;
    logic             is_shift;

    assign mode_s = mode_e'(mode);

    always_comb begin
        q_d      = q_q;
        is_shift = 1'b0;
        if (en) begin
            case (mode_s)
                M_HOLD: q_d = q_q;
                M_LOAD: q_d = d;
                M_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_r};
                    is_shift = 1'b1;
                end
                M_SHR: begin
                    q_d      = {sin_l, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                M_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                M_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                M_ASR: begin
                    q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                M_CLR:   q_d = RST_VAL;
                default: q_d = q_q;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (mode_s == M_LOAD || mode_s == M_CLR) begin
                cnt_d = '0;
            end else if (is_shift && cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // zero is derived from the next-state value so it lands on the same edge
    // as q; with en=0 q_d equals q_q and the flag simply re-registers itself.
    always_ff @(posedge clk2 or posedge a_reset) begin
        if (a_reset) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            zero_q <= (RST_VAL == '0);
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            zero_q <= (q_d == '0);
        end
    end

    assign q         = q_q;
    assign sout_l    = q_q[WIDTH-1];
    assign sout_r    = q_q[0];
    assign zero      = zero_q;
    assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_univ
//   Drives two shift_reg_univ instances (RST_VAL 8'h00 and 8'h5A) with the
//   same stimulus and compares every output against an arithmetic reference
//   model after each clock edge and during asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_shift_reg_univ;

    logic       clk2;
    logic       a_reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;

    logic [7:0] q0, q1;
    logic       sl0, sl1, sr0, sr1, z0, z1;
    logic [3:0] c0, c1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state, one slot per instance
    int mq [2];
    int mc [2];
    int rv [2];

    shift_reg_univ u_dut0 (
        .clk2(clk2), .a_reset(a_reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q0), .sout_l(sl0), .sout_r(sr0),
        .zero(z0), .shift_cnt(c0)
    );

    shift_reg_univ #(.WIDTH(8), .RST_VAL(8'h5A), .CNT_W(4)) u_dut1 (
        .clk2(clk2), .a_reset(a_reset), .en(en), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .q(q1), .sout_l(sl1), .sout_r(sr1),
        .zero(z1), .shift_cnt(c1)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_next(input int qv, input int m, input int dv,
                                    input int sl, input int sr, input int rst);
        case (m)
            0: return qv;
            1: return dv;
            2: return ((qv * 2) + sr) % 256;
            3: return (qv / 2) + sl * 128;
            4: return ((qv * 2) % 256) + (qv / 128);
            5: return (qv / 2) + (qv % 2) * 128;
            6: return (qv / 2) + ((qv >= 128) ? 128 : 0);
            default: return rst;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = rv[i];
            mc[i] = 0;
        end
    endtask

    task automatic model_edge(input int e, input int m, input int dv, input int sl, input int sr);
        if (e == 0) return;
        for (int i = 0; i < 2; i++) begin
            mq[i] = ref_next(mq[i], m, dv, sl, sr, rv[i]);
            if (m == 1 || m == 7) mc[i] = 0;
            else if (m != 0 && mc[i] < 15) mc[i] = mc[i] + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q0"},   32'(q0),  32'(mq[0]));
        chk({tag, ".sl0"},  32'(sl0), 32'(mq[0] / 128));
        chk({tag, ".sr0"},  32'(sr0), 32'(mq[0] % 2));
        chk({tag, ".z0"},   32'(z0),  32'(mq[0] == 0));
        chk({tag, ".c0"},   32'(c0),  32'(mc[0]));
        chk({tag, ".q1"},   32'(q1),  32'(mq[1]));
        chk({tag, ".sl1"},  32'(sl1), 32'(mq[1] / 128));
        chk({tag, ".sr1"},  32'(sr1), 32'(mq[1] % 2));
        chk({tag, ".z1"},   32'(z1),  32'(mq[1] == 0));
        chk({tag, ".c1"},   32'(c1),  32'(mc[1]));
    endtask

    // drive inputs, take one clock edge, sample 1 time unit later
    task automatic apply(input string tag, input logic e, input logic [2:0] m,
                         input logic [7:0] dv, input logic sl, input logic sr);
        en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
        @(posedge clk2);
        #1;
        model_edge(int'(e), int'(m), int'(dv), int'(sl), int'(sr));
        check_all(tag);
    endtask

    // asynchronous pulse between edges; checked while asserted, before any edge
    task automatic pulse_reset(input string tag);
        #2 a_reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 a_reset = 1'b0;
    endtask

    initial begin
        rv[0] = 8'h00;
        rv[1] = 8'h5A;
        a_reset = 1'b1;
        en = 1'b0; mode = 3'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
        #2;
        model_reset();
        check_all("por");
        chk("por.z1_const", 32'(z1), 32'd0);
        #10 a_reset = 1'b0;

        // 1: async reset from q=A5 before the next edge
        apply("t1.load", 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
        pulse_reset("t1.rst");
        chk("t1.q0", 32'(q0), 32'h00);
        chk("t1.z0", 32'(z0), 32'd1);

        // 2: LOAD 81, SHL sin_r=1
        apply("t2.load", 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        apply("t2.shl",  1'b1, 3'd2, 8'hFF, 1'b1, 1'b1);
        chk("t2.q0",  32'(q0),  32'h03);
        chk("t2.sl0", 32'(sl0), 32'd0);
        chk("t2.c0",  32'(c0),  32'd1);

        // 3: LOAD 80, ASR x3, SHR sin_l=0
        apply("t3.load", 1'b1, 3'd1, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply("t3.asr", 1'b1, 3'd6, 8'h00, 1'b0, 1'b1);
        chk("t3.q0", 32'(q0), 32'hF0);
        chk("t3.c0", 32'(c0), 32'd3);
        apply("t3.shr", 1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
        chk("t3.q0b", 32'(q0), 32'h78);

        // 4: LOAD 01, ROR, ROL, then en=0
        apply("t4.load", 1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
        apply("t4.ror",  1'b1, 3'd5, 8'h00, 1'b1, 1'b1);
        chk("t4.q0ror", 32'(q0), 32'h80);
        apply("t4.rol",  1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
        chk("t4.q0rol", 32'(q0), 32'h01);
        apply("t4.en0",  1'b0, 3'd1, 8'hFF, 1'b1, 1'b1);
        chk("t4.q0hold", 32'(q0), 32'h01);
        chk("t4.c0hold", 32'(c0), 32'd2);

        // 5: saturation, then LOAD clears; rotate of all-ones is unchanged
        apply("t5.load", 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) apply("t5.rol", 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        chk("t5.q0",  32'(q0), 32'hFF);
        chk("t5.c0",  32'(c0), 32'd15);
        apply("t5.load2", 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        chk("t5.c0clr", 32'(c0), 32'd0);

        // 6: SHR to zero, then CLR
        apply("t6.load", 1'b1, 3'd1, 8'h01, 1'b1, 1'b1);
        apply("t6.shr",  1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
        chk("t6.q0", 32'(q0), 32'h00);
        chk("t6.z0", 32'(z0), 32'd1);
        apply("t6.clr",  1'b1, 3'd7, 8'hFF, 1'b1, 1'b1);
        chk("t6.q1", 32'(q1), 32'h5A);
        chk("t6.z1", 32'(z1), 32'd0);

        // reset held across an edge dominates en/mode
        apply("rd.load", 1'b1, 3'd1, 8'hC3, 1'b0, 1'b0);
        a_reset = 1'b1; en = 1'b1; mode = 3'd1; d = 8'hFF;
        @(posedge clk2);
        #1;
        model_reset();
        check_all("rd.held");
        a_reset = 1'b0;

        // randomized stimulus with occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            apply("rnd", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 39) == 0) pulse_reset("rnd.rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
